// File: rtl/vram_dump_tx_pkg.sv
// Shared constants, FSM state type and frame helper for the VRAM read-back streamer.
package vram_dump_tx_pkg;

    // UART frame layout: one start bit, eight data bits, one stop bit.
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    // VRAM geometry, shared with the UART-RX upload path.
    localparam int VRAM_DEPTH  = 22500;
    localparam int VRAM_ADDR_W = 15;
    localparam int DUMP_LEN_W  = 15;

    // Dump sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_CAP   = 3'd2,
        ST_SEND  = 3'd3,
        ST_DRAIN = 3'd4
    } dump_state_e;

    // Full 8N1 frame for one byte, bit 0 goes on the line first.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_BITS-1:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/vram_dump_tx_if.sv
// Request, VRAM user-port and status signals of the VRAM read-back streamer.
interface vram_dump_tx_if
    import vram_dump_tx_pkg::*;
#(
    parameter int ADDR_W = vram_dump_tx_pkg::VRAM_ADDR_W,
    parameter int LEN_W  = vram_dump_tx_pkg::DUMP_LEN_W
) ();

    logic                 start;
    logic [ADDR_W-1:0]    start_addr;
    logic [LEN_W-1:0]     length;
    logic [ADDR_W-1:0]    vram_addr;
    logic [DATA_BITS-1:0] vram_data;
    logic                 tx;
    logic                 busy;
    logic                 done;
    logic                 err;

    // Requester / VRAM side.
    modport master (
        output start,
        output start_addr,
        output length,
        output vram_data,
        input  vram_addr,
        input  tx,
        input  busy,
        input  done,
        input  err
    );

    // Streamer side.
    modport slave (
        input  start,
        input  start_addr,
        input  length,
        input  vram_data,
        output vram_addr,
        output tx,
        output busy,
        output done,
        output err
    );

endinterface

// File: rtl/vram_dump_tx_uart_tx.sv
// 8N1 UART transmitter with valid/ready input; ready also rises in the last
// cycle of a stop bit so consecutive frames follow without an idle gap.
module vram_dump_tx_uart_tx
    import vram_dump_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 926
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 tx_o,
    output logic                 idle_o
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam int IDX_W = $clog2(FRAME_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);

    logic                  active_q, active_d;
    logic [BAUD_W-1:0]     baud_q,   baud_d;
    logic [IDX_W-1:0]      idx_q,    idx_d;
    logic [FRAME_BITS-1:0] shift_q,  shift_d;
    logic                  tx_q,     tx_d;

    logic                  bit_end_s;
    logic                  last_bit_s;
    logic                  ready_s;
    logic                  load_s;
    logic [FRAME_BITS-1:0] frame_s;

    // Bit-boundary and handshake decode from the current counters.
    always_comb begin
        bit_end_s  = active_q && (baud_q == BAUD_LAST);
        last_bit_s = bit_end_s && (idx_q == IDX_LAST);
        ready_s    = !active_q || last_bit_s;
        load_s     = ready_s && valid_i;
        frame_s    = build_frame(data_i);
    end

    // Next-state for the shifter: load a frame, advance a bit, or count baud ticks.
    always_comb begin
        active_d = active_q;
        baud_d   = baud_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        if (load_s) begin
            active_d = 1'b1;
            baud_d   = {BAUD_W{1'b0}};
            idx_d    = {IDX_W{1'b0}};
            shift_d  = frame_s;
            tx_d     = frame_s[0];
        end else if (last_bit_s) begin
            active_d = 1'b0;
            baud_d   = {BAUD_W{1'b0}};
            idx_d    = {IDX_W{1'b0}};
            tx_d     = 1'b1;
        end else if (bit_end_s) begin
            baud_d   = {BAUD_W{1'b0}};
            idx_d    = idx_q + IDX_W'(1);
            shift_d  = {1'b1, shift_q[FRAME_BITS-1:1]};
            tx_d     = shift_q[1];
        end else if (active_q) begin
            baud_d   = baud_q + BAUD_W'(1);
        end else begin
            tx_d     = 1'b1;
        end
    end

    // Shifter state; the line is forced high the instant reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            baud_q   <= {BAUD_W{1'b0}};
            idx_q    <= {IDX_W{1'b0}};
            shift_q  <= {FRAME_BITS{1'b1}};
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            baud_q   <= baud_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

    assign ready_o = ready_s;
    assign tx_o    = tx_q;
    assign idle_o  = !active_q;

endmodule

// File: rtl/vram_dump_tx.sv
// VRAM read-back streamer: reads a wrap-around byte range through the VRAM
// user port and sends each byte over UART, prefetching the next byte while
// the current one shifts out.
module vram_dump_tx
    import vram_dump_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 926,
    parameter int DEPTH        = vram_dump_tx_pkg::VRAM_DEPTH,
    parameter int ADDR_W       = vram_dump_tx_pkg::VRAM_ADDR_W,
    parameter int LEN_W        = vram_dump_tx_pkg::DUMP_LEN_W
) (
    input  logic          clk,
    input  logic          rst_n,
    vram_dump_tx_if.slave bus
);

    localparam int ADDR_X_W = ADDR_W + 1;
    localparam logic [ADDR_X_W-1:0] DEPTH_X   = ADDR_X_W'(DEPTH);
    localparam logic [ADDR_W-1:0]   ADDR_LAST = ADDR_W'(DEPTH - 1);

    dump_state_e          state_q,      state_d;
    logic [ADDR_W-1:0]    addr_q,       addr_d;
    logic [LEN_W-1:0]     remain_q,     remain_d;
    logic [DATA_BITS-1:0] hold_q,       hold_d;
    logic                 hold_valid_q, hold_valid_d;
    logic                 busy_q,       busy_d;
    logic                 done_q,       done_d;
    logic                 err_q,        err_d;

    logic                 tx_ready_s;
    logic                 tx_idle_s;
    logic                 tx_line_s;
    logic                 accept_s;

    // Address after a, wrapping from the last VRAM byte back to 0.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        if (a == ADDR_LAST) begin
            return {ADDR_W{1'b0}};
        end else begin
            return a + ADDR_W'(1);
        end
    endfunction

    vram_dump_tx_uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (hold_q),
        .valid_i (hold_valid_q),
        .ready_o (tx_ready_s),
        .tx_o    (tx_line_s),
        .idle_o  (tx_idle_s)
    );

    assign accept_s = hold_valid_q && tx_ready_s;

    // Dump sequencer next-state, counters and one-cycle status pulses.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remain_d     = remain_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if ({1'b0, bus.start_addr} >= DEPTH_X) begin
                        err_d = 1'b1;
                    end else if (bus.length == {LEN_W{1'b0}}) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d   = bus.start_addr;
                        remain_d = bus.length;
                        busy_d   = 1'b1;
                        state_d  = ST_RD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                state_d = ST_CAP;
            end
            ST_CAP: begin
                hold_d       = bus.vram_data;
                hold_valid_d = 1'b1;
                addr_d       = wrap_inc(addr_q);
                remain_d     = remain_q - LEN_W'(1);
                state_d      = ST_SEND;
            end
            ST_SEND: begin
                if (accept_s) begin
                    hold_valid_d = 1'b0;
                    if (remain_q != {LEN_W{1'b0}}) begin
                        state_d = ST_RD;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_DRAIN: begin
                // The transmitter is mid-frame on entry, so ready here marks the
                // final cycle of the last stop bit; done then lands one cycle later.
                if (tx_idle_s || tx_ready_s) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                busy_d       = 1'b0;
                hold_valid_d = 1'b0;
            end
        endcase
    end

    // Sequencer registers; reset abandons any dump in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= {ADDR_W{1'b0}};
            remain_q     <= {LEN_W{1'b0}};
            hold_q       <= {DATA_BITS{1'b0}};
            hold_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remain_q     <= remain_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.vram_addr = addr_q;
    assign bus.tx        = tx_line_s;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule
